fetch_sequencer: RTL
====================

// Module: fetch_sequencer
// PURPOSE
//  Downstream consumer of the 4-way-read / 1-write interleaved instruction SRAM (8 banks, 72-bit entries).
//  Holds the fetch PC and issues 4 consecutive entry addresses per read (PC..PC+3).
//  Captures the 4x72-bit SRAM response one cycle after the read.
//  Buffers responses in a 2-entry queue toward decode using a valid/ready handshake.
//  Handles redirect (flush) and start/stop.
//  Never reads while the refill writer owns the SRAM.
// PARAMETERS
//  ADDR_W   8   entry address width (SRAM depth 2**ADDR_W, addresses wrap mod 256)
//  ENTRY_W  72  bits per SRAM entry (one 9-byte instruction slot)
//  LANES    4   read lanes per fetch; PC step per issue
//  DEPTH    2   output queue entries
// PORTS
//  i_fire        in   1        clock, all state on rising edge
//  rst           in   1        synchronous active-high reset
//  i_start       in   1        IDLE->FETCH, load PC from i_start_pc
//  i_start_pc    in   8        first fetch address
//  i_stop        in   1        flush, return to IDLE
//  i_redirect    in   1        flush, PC <= i_redirect_pc
//  i_redirect_pc in   8        redirect target
//  i_write_busy  in   1        refill writer active; no read may be issued
//  o_read_en     out  1        SRAM read enable
//  o_readAddr    out  32       {PC+3,PC+2,PC+1,PC} lanes, 8 bits each, lane0 = [7:0]
//  i_datas       in   288      SRAM data, lane k = [k*72+:72], valid cycle after o_read_en
//  o_valid       out  1        queue head valid
//  i_ready       in   1        decode accepts head when o_valid&&i_ready
//  o_pc          out  8        entry address of lane0 of head
//  o_insts       out  288      head data, same lane order as i_datas
// BEHAVIOUR
//  Reset: state=IDLE, PC=0, queue empty, inflight=0.
//   Outputs after reset: o_read_en=0, o_readAddr=0, o_valid=0, o_pc=0, o_insts=0.
//  o_readAddr and o_read_en are combinational from registered PC/state/credits.
//  FSM:
//   IDLE  : no reads.
//     i_start -> FETCH, PC<=i_start_pc.
//   FETCH : o_read_en = !i_write_busy && !i_redirect && !i_stop && credit.
//     On issue: PC<=PC+4 (mod 256), inflight<=1, tag captured pc.
//     Lanes wrap independently: PC=0xFE gives lanes FE,FF,00,01.
//  Credit: occ + inflight - pop < DEPTH, where pop = o_valid&&i_ready.
//   A full queue popped this cycle may issue.
//  Response: cycle after issue, if inflight && !killed, push {tag_pc, i_datas}; inflight<=0.
//   Latency: issue edge N -> o_valid high in cycle N+2 (no bypass).
//  Redirect (FETCH only; ignored in IDLE):
//   - queue emptied, o_valid=0 next cycle;
//   - any inflight response discarded (kill);
//   - PC<=i_redirect_pc, no issue that cycle; first new issue the next cycle.
//  i_stop: same flush, then -> IDLE. i_stop has priority over i_redirect, which has priority over i_start.
//  Simultaneous push+pop at full: allowed, occupancy unchanged.
//  Push while full is unreachable by credit rule; assert in sim.
//  o_insts/o_pc stable while o_valid && !i_ready.
//  i_write_busy mid-FETCH: issue stalls, PC holds.
//   An inflight response issued before busy rose is still captured.
//  rst mid-operation: return to reset values next cycle; inflight response dropped.
// STRUCTURE
//  Package fetch_pkg: ADDR_W, ENTRY_W, LANES, FETCH_W=LANES*ENTRY_W (288), state enum {IDLE,FETCH}.
//  Sub-module fetch_queue: DEPTH-entry FIFO of {pc[7:0], data[287:0]}.
//   Ports: push, pop, flush, occ; sync reset.
//  Top: PC, FSM, credit/inflight/kill logic.
// TESTING
//  1 rst, then idle 5 cycles -> o_read_en=0, o_valid=0, o_readAddr=0 throughout.
//  2 i_start, i_start_pc=0x10, i_ready=1 -> addrs 0x13121110, 0x17161514, ...
//    o_valid 2 cycles after first issue, o_pc 0x10, 0x14 each cycle.
//  3 i_ready=0 from start -> exactly 2 reads issued, then o_read_en=0.
//    Head pc=0x10 stable; i_ready=1 for 1 cycle -> one new read (pc 0x18) that cycle.
//  4 i_redirect_pc=0x40 in cycle after an issue -> that response never appears.
//    Next o_pc=0x40, queue emptied.
//  5 i_start_pc=0xFC -> lanes FC..FF, then 00,01,02,03; o_pc 0xFC, 0x00.
//  6 i_write_busy=1 for 3 cycles mid-run -> no o_read_en, PC holds, prior inflight still delivered.
//    rst during run -> all outputs to reset values next cycle.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared widths, FSM state type and queue entry layout for the instruction fetch sequencer.
package fetch_pkg;
   localparam int ADDR_W  = 8;
   localparam int ENTRY_W = 72;
   localparam int LANES   = 4;
   localparam int FETCH_W = LANES * ENTRY_W;
   localparam int DEPTH   = 2;
   localparam int OCC_W   = $clog2(DEPTH + 1);

   typedef enum logic {
      IDLE  = 1'b0,
      FETCH = 1'b1
   } state_e;

   typedef struct packed {
      logic [ADDR_W-1:0]  pc;
      logic [FETCH_W-1:0] data;
   } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// Small FIFO of fetch responses toward decode; flush drops every entry in one cycle.
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int DEPTH_P = DEPTH
) (
   input  logic                               clk_sys,
   input  logic                               rst,
   input  logic                               push,
   input  fetch_entry_t                       push_entry,
   input  logic                               pop,
   input  logic                               flush,
   output logic [$clog2(DEPTH_P + 1)-1:0]     occ,
   output logic                               head_valid,
   output fetch_entry_t                       head
);
   localparam int PTR_W = (DEPTH_P > 1) ? $clog2(DEPTH_P) : 1;
   localparam int Q_OCC_W = $clog2(DEPTH_P + 1);

   fetch_entry_t       mem_q [DEPTH_P];
   fetch_entry_t       mem_d [DEPTH_P];
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [Q_OCC_W-1:0] occ_q, occ_d;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH_P - 1)) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      mem_d    = mem_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      occ_d    = occ_q;
      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         occ_d    = '0;
      end else begin
         // At full, push and pop together reuse the slot being vacated.
         if (push) begin
            mem_d[wr_ptr_q] = push_entry;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
         end
         if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
         end
         occ_d = occ_q + Q_OCC_W'(push) - Q_OCC_W'(pop);
      end
   end

   always_ff @(posedge clk_sys) begin
      if (rst) begin
         for (int i = 0; i < DEPTH_P; i++) begin
            mem_q[i] <= '0;
         end
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         occ_q    <= '0;
      end else begin
         mem_q    <= mem_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         occ_q    <= occ_d;
      end
   end

   assign occ        = occ_q;
   assign head_valid = (occ_q != '0);
   assign head       = mem_q[rd_ptr_q];

   a_no_overflow: assert property (@(posedge clk_sys) disable iff (rst)
      !(push && !pop && !flush && occ_q == Q_OCC_W'(DEPTH_P)));
endmodule

// File: rtl/fetch_sequencer.sv
// Fetch PC / read-issue controller in front of the 4-lane instruction SRAM.
//
// state | meaning
// IDLE  | no reads issued; waits for i_start
// FETCH | issues 4-lane reads whenever the SRAM is free and the queue has credit
module fetch_sequencer
   import fetch_pkg::*;
(
   input  logic                      i_fire,
   input  logic                      rst,
   input  logic                      i_start,
   input  logic [ADDR_W-1:0]         i_start_pc,
   input  logic                      i_stop,
   input  logic                      i_redirect,
   input  logic [ADDR_W-1:0]         i_redirect_pc,
   input  logic                      i_write_busy,
   output logic                      o_read_en,
   output logic [LANES*ADDR_W-1:0]   o_readAddr,
   input  logic [FETCH_W-1:0]        i_datas,
   output logic                      o_valid,
   input  logic                      i_ready,
   output logic [ADDR_W-1:0]         o_pc,
   output logic [FETCH_W-1:0]        o_insts
);
   localparam int CNT_W = OCC_W + 1;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] tag_q, tag_d;
   logic              inflight_q, inflight_d;

   logic              flush, pop, push, read_en, credit;
   logic [OCC_W-1:0]  occ;
   logic              head_valid;
   fetch_entry_t      head;
   fetch_entry_t      push_entry;

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      tag_d      = tag_q;
      inflight_d = 1'b0;

      pop   = head_valid && i_ready;
      flush = i_stop || (state_q == FETCH && i_redirect);
      // Entries held plus the one in flight must leave room, counting a pop this cycle.
      credit  = (CNT_W'(occ) + CNT_W'(inflight_q)) < (CNT_W'(DEPTH) + CNT_W'(pop));
      read_en = (state_q == FETCH) && !i_write_busy && !i_redirect && !i_stop && credit;
      push    = inflight_q && !flush;

      if (read_en) begin
         inflight_d = 1'b1;
         tag_d      = pc_q;
         pc_d       = pc_q + ADDR_W'(LANES);
      end

      if (i_stop) begin
         state_d = IDLE;
      end else if (state_q == FETCH && i_redirect) begin
         pc_d = i_redirect_pc;
      end else if (state_q == IDLE && i_start) begin
         state_d = FETCH;
         pc_d    = i_start_pc;
      end
   end

   always_comb begin
      o_readAddr = '0;
      if (state_q == FETCH) begin
         for (int k = 0; k < LANES; k++) begin
            o_readAddr[k*ADDR_W +: ADDR_W] = pc_q + ADDR_W'(k);
         end
      end
   end

   always_ff @(posedge i_fire) begin
      if (rst) begin
         state_q    <= IDLE;
         pc_q       <= '0;
         tag_q      <= '0;
         inflight_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         tag_q      <= tag_d;
         inflight_q <= inflight_d;
      end
   end

   assign push_entry = '{pc: tag_q, data: i_datas};

   fetch_queue #(.DEPTH_P(DEPTH)) u_queue (
      .clk_sys    (i_fire),
      .rst        (rst),
      .push       (push),
      .push_entry (push_entry),
      .pop        (pop),
      .flush      (flush),
      .occ        (occ),
      .head_valid (head_valid),
      .head       (head)
   );

   assign o_read_en = read_en;
   assign o_valid   = head_valid;
   assign o_pc      = head_valid ? head.pc : '0;
   assign o_insts   = head_valid ? head.data : '0;
endmodule
